// File: rtl/alu_pkg.sv
// Shared opcode encoding and default datapath width for the registered ALU.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [3:0] {
        CTL_SELB  = 4'd0,
        CTL_INCB  = 4'd1,
        CTL_DECB  = 4'd2,
        CTL_ADD   = 4'd3,
        CTL_ADDC  = 4'd4,
        CTL_SUB   = 4'd5,
        CTL_SUBB  = 4'd6,
        CTL_AND   = 4'd7,
        CTL_OR    = 4'd8,
        CTL_XOR   = 4'd9,
        CTL_NOTB  = 4'd10,
        CTL_SHL   = 4'd11,
        CTL_SHR   = 4'd12,
        CTL_RSV13 = 4'd13,
        CTL_RSV14 = 4'd14,
        CTL_RSV15 = 4'd15
    } ctl_e;

endpackage

// File: rtl/alu_if.sv
// Signal bundle between an ALU driver and alu_unit.
interface alu_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) (
    input logic clk,
    input logic reset
);
    // valid_in qualifies a/b/cin/ctl for the edge it is sampled on; there is no
    // ready, every cycle is accepted. valid_out marks the result registers as
    // loaded on the last edge; alu/carry/zero hold their value otherwise.
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       ctl;
    logic             valid_out;
    logic [WIDTH-1:0] alu;
    logic             carry;
    logic             zero;

    modport master (
        input  clk, reset, valid_out, alu, carry, zero,
        output valid_in, a, b, cin, ctl
    );

    modport slave (
        input  valid_in, a, b, cin, ctl,
        output valid_out, alu, carry, zero
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational opcode decode: result, carry/borrow and zero for one operation.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       ctl,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] aExt;
    logic [WIDTH:0] bExt;
    logic [WIDTH:0] cinExt;
    logic [WIDTH:0] wide;
    ctl_e           op;

    assign aExt   = {1'b0, a};
    assign bExt   = {1'b0, b};
    assign cinExt = {{WIDTH{1'b0}}, cin};
    assign op     = ctl_e'(ctl);

    // Arithmetic runs one bit wider; the extra bit is the carry, or the
    // borrow for subtractions since the unsigned difference wraps negative.
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        case (op)
            CTL_SELB: wide = bExt;
            CTL_INCB: begin wide = bExt + ONE;           carry = wide[WIDTH]; end
            CTL_DECB: begin wide = bExt - ONE;           carry = wide[WIDTH]; end
            CTL_ADD:  begin wide = aExt + bExt;          carry = wide[WIDTH]; end
            CTL_ADDC: begin wide = aExt + bExt + cinExt; carry = wide[WIDTH]; end
            CTL_SUB:  begin wide = aExt - bExt;          carry = wide[WIDTH]; end
            CTL_SUBB: begin wide = aExt - bExt - cinExt; carry = wide[WIDTH]; end
            CTL_AND:  wide = {1'b0, a & b};
            CTL_OR:   wide = {1'b0, a | b};
            CTL_XOR:  wide = {1'b0, a ^ b};
            CTL_NOTB: wide = {1'b0, ~b};
            CTL_SHL:  begin wide = {1'b0, a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
            CTL_SHR:  begin wide = {2'b00, a[WIDTH-1:1]};      carry = a[0];       end
            default:  wide = '0;
        endcase
        result = wide[WIDTH-1:0];
        zero   = (wide[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: one-cycle latency, valid-qualified loads, synchronous reset.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic   clk,
    input logic   reset,
    alu_if.slave  bus
);
    logic [WIDTH-1:0] nextAlu;
    logic             nextCarry;
    logic             nextZero;

    logic             validReg;
    logic [WIDTH-1:0] aluReg;
    logic             carryReg;
    logic             zeroReg;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (bus.a),
        .b      (bus.b),
        .cin    (bus.cin),
        .ctl    (bus.ctl),
        .result (nextAlu),
        .carry  (nextCarry),
        .zero   (nextZero)
    );

    // Reset wins over valid_in, so an operation presented with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            validReg <= 1'b0;
            aluReg   <= '0;
            carryReg <= 1'b0;
            zeroReg  <= 1'b0;
        end else begin
            validReg <= bus.valid_in;
            if (bus.valid_in) begin
                aluReg   <= nextAlu;
                carryReg <= nextCarry;
                zeroReg  <= nextZero;
            end
        end
    end

    assign bus.valid_out = validReg;
    assign bus.alu       = aluReg;
    assign bus.carry     = carryReg;
    assign bus.zero      = zeroReg;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: reset, each opcode group, hold and streaming.
module tb_alu_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] expAlu;
        logic         expCarry;
        logic         expZero;
    } vec_t;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    alu_if #(.WIDTH(W)) bus (.clk(clk), .reset(reset));

    alu_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one valid operation and step past the edge that samples it.
    task automatic apply(input logic [3:0] ctl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        bus.valid_in = 1'b1;
        bus.ctl      = ctl;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W+2:0] obs;
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.ctl      = 4'd3;
        bus.a        = 4'd5;
        bus.b        = 4'd3;
        bus.cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus.valid_out, bus.carry, bus.zero, bus.alu};
        testsRun++;
        if (obs !== 7'b0) begin
            testsFailed++;
            $display("FAIL reset: {vout,carry,zero,alu}=%b expected %b", obs, 7'b0);
        end
        reset        = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_vectors(input string name, input vec_t v[$]);
        logic [W+2:0] obs;
        logic [W+2:0] exp;
        foreach (v[i]) begin
            apply(v[i].ctl, v[i].a, v[i].b, v[i].cin);
            obs = {bus.valid_out, bus.carry, bus.zero, bus.alu};
            exp = {1'b1, v[i].expCarry, v[i].expZero, v[i].expAlu};
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("FAIL %s[%0d] ctl=%0d a=%0d b=%0d cin=%0d: vout=%0d carry=%0d zero=%0d alu=%0d expected vout=%0d carry=%0d zero=%0d alu=%0d",
                         name, i, v[i].ctl, v[i].a, v[i].b, v[i].cin,
                         obs[W+2], obs[W+1], obs[W], obs[W-1:0],
                         exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_add();
        vec_t v[$];
        v.push_back('{4'd3, 4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b0});
        v.push_back('{4'd4, 4'd7, 4'd8, 1'b1, 4'd0, 1'b1, 1'b1});
        v.push_back('{4'd3, 4'd5, 4'd5, 1'b1, 4'd10, 1'b0, 1'b0}); // cin ignored
        v.push_back('{4'd4, 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0});
        test_vectors("add", v);
    endtask

    task automatic test_sub();
        vec_t v[$];
        v.push_back('{4'd5, 4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0});
        v.push_back('{4'd6, 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1});
        v.push_back('{4'd6, 4'd5, 4'd5, 1'b1, 4'd15, 1'b1, 1'b0});
        v.push_back('{4'd5, 4'd9, 4'd4, 1'b1, 4'd5, 1'b0, 1'b0}); // cin ignored
        test_vectors("sub", v);
    endtask

    task automatic test_incdec();
        vec_t v[$];
        v.push_back('{4'd1, 4'd0, 4'd15, 1'b0, 4'd0, 1'b1, 1'b1});
        v.push_back('{4'd2, 4'd0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0});
        v.push_back('{4'd2, 4'd3, 4'd5, 1'b1, 4'd4, 1'b0, 1'b0});
        test_vectors("incdec", v);
    endtask

    task automatic test_logic();
        vec_t v[$];
        v.push_back('{4'd7, 4'd12, 4'd10, 1'b0, 4'd8, 1'b0, 1'b0});
        v.push_back('{4'd8, 4'd12, 4'd10, 1'b0, 4'd14, 1'b0, 1'b0});
        v.push_back('{4'd9, 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1});
        v.push_back('{4'd10, 4'd0, 4'd5, 1'b0, 4'd10, 1'b0, 1'b0});
        v.push_back('{4'd11, 4'd9, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0});
        v.push_back('{4'd12, 4'd9, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0});
        v.push_back('{4'd0, 4'd3, 4'd7, 1'b1, 4'd7, 1'b0, 1'b0});
        v.push_back('{4'd14, 4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 1'b1});
        test_vectors("logic", v);
    endtask

    task automatic test_hold();
        apply(4'd3, 4'd1, 4'd1, 1'b0);
        testsRun++;
        if (bus.valid_out !== 1'b1 || bus.alu !== 4'd2) begin
            testsFailed++;
            $display("FAIL hold_load: vout=%0d alu=%0d expected vout=1 alu=2", bus.valid_out, bus.alu);
        end
        bus.valid_in = 1'b0;
        bus.ctl      = 4'd3;
        bus.a        = 4'd15;
        bus.b        = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (bus.valid_out !== 1'b0 || bus.alu !== 4'd2 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin
                testsFailed++;
                $display("FAIL hold[%0d]: vout=%0d alu=%0d carry=%0d zero=%0d expected vout=0 alu=2 carry=0 zero=0",
                         i, bus.valid_out, bus.alu, bus.carry, bus.zero);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(4'd3, 4'd1, 4'd1, 1'b0);
        reset = 1'b1;
        apply(4'd3, 4'd2, 4'd2, 1'b0);
        testsRun++;
        if ({bus.valid_out, bus.carry, bus.zero, bus.alu} !== 7'b0) begin
            testsFailed++;
            $display("FAIL reset_mid: vout=%0d carry=%0d zero=%0d alu=%0d expected all 0",
                     bus.valid_out, bus.carry, bus.zero, bus.alu);
        end
        reset = 1'b0;
        apply(4'd3, 4'd3, 4'd3, 1'b0);
        testsRun++;
        if (bus.valid_out !== 1'b1 || bus.alu !== 4'd6) begin
            testsFailed++;
            $display("FAIL reset_release: vout=%0d alu=%0d expected vout=1 alu=6", bus.valid_out, bus.alu);
        end
        bus.valid_in = 1'b0;
    endtask

    // a=6, b=11, cin=1 through every opcode with no gaps.
    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back('{4'd0,  4'd6, 4'd11, 1'b1, 4'd11, 1'b0, 1'b0});
        v.push_back('{4'd1,  4'd6, 4'd11, 1'b1, 4'd12, 1'b0, 1'b0});
        v.push_back('{4'd2,  4'd6, 4'd11, 1'b1, 4'd10, 1'b0, 1'b0});
        v.push_back('{4'd3,  4'd6, 4'd11, 1'b1, 4'd1,  1'b1, 1'b0});
        v.push_back('{4'd4,  4'd6, 4'd11, 1'b1, 4'd2,  1'b1, 1'b0});
        v.push_back('{4'd5,  4'd6, 4'd11, 1'b1, 4'd11, 1'b1, 1'b0});
        v.push_back('{4'd6,  4'd6, 4'd11, 1'b1, 4'd10, 1'b1, 1'b0});
        v.push_back('{4'd7,  4'd6, 4'd11, 1'b1, 4'd2,  1'b0, 1'b0});
        v.push_back('{4'd8,  4'd6, 4'd11, 1'b1, 4'd15, 1'b0, 1'b0});
        v.push_back('{4'd9,  4'd6, 4'd11, 1'b1, 4'd13, 1'b0, 1'b0});
        v.push_back('{4'd10, 4'd6, 4'd11, 1'b1, 4'd4,  1'b0, 1'b0});
        v.push_back('{4'd11, 4'd6, 4'd11, 1'b1, 4'd12, 1'b0, 1'b0});
        v.push_back('{4'd12, 4'd6, 4'd11, 1'b1, 4'd3,  1'b0, 1'b0});
        v.push_back('{4'd13, 4'd6, 4'd11, 1'b1, 4'd0,  1'b0, 1'b1});
        v.push_back('{4'd14, 4'd6, 4'd11, 1'b1, 4'd0,  1'b0, 1'b1});
        v.push_back('{4'd15, 4'd6, 4'd11, 1'b1, 4'd0,  1'b0, 1'b1});
        test_vectors("b2b", v);
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.ctl      = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_incdec();
        test_logic();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
